// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32 control sequencer.
package ctrl_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned OP_W    = 7;

   localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] S_FETCH  = 3'd1;
   localparam logic [STATE_W-1:0] S_DECODE = 3'd2;
   localparam logic [STATE_W-1:0] S_EXEC   = 3'd3;
   localparam logic [STATE_W-1:0] S_MEM    = 3'd4;
   localparam logic [STATE_W-1:0] S_WB     = 3'd5;
   localparam logic [STATE_W-1:0] S_HALT   = 3'd6;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_R    = 3'd1,
      CLS_I    = 3'd2,
      CLS_LD   = 3'd3,
      CLS_ST   = 3'd4,
      CLS_ILL  = 3'd5
   } cls_e;

   localparam logic [OP_W-1:0] OP_R  = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I  = 7'b0010011;
   localparam logic [OP_W-1:0] OP_LD = 7'b0000011;
   localparam logic [OP_W-1:0] OP_ST = 7'b0100011;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   // Registered Moore control outputs driven to the datapath
   typedef struct packed {
      logic       ir_we;
      logic       pc_we;
      logic       reg_we;
      logic       mem_req;
      logic       mem_we;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       wb_sel;
      logic       busy;
      logic       illegal;
   } ctrl_out_t;

   function automatic cls_e decode_op(input logic [OP_W-1:0] op);
      cls_e cls;
      case (op)
         OP_R:    cls = CLS_R;
         OP_I:    cls = CLS_I;
         OP_LD:   cls = CLS_LD;
         OP_ST:   cls = CLS_ST;
         default: cls = CLS_ILL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 datapath: FETCH/DECODE/EXEC/MEM/WB with
// memory-ready handshake, retired-instruction counter and halt on illegal opcode.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [6:0]       op_i,
   input  logic             mem_ready_i,
   output logic             ir_we_o,
   output logic             pc_we_o,
   output logic             reg_we_o,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             alu_src_o,
   output logic [1:0]       alu_op_o,
   output logic             wb_sel_o,
   output logic             busy_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] retired_o
);

   logic [STATE_W-1:0] state_q, state_d;
   cls_e               cls_q, cls_d;
   ctrl_out_t          out_q, out_d;
   logic [CNT_W-1:0]   retired_q;
   logic               st_commit_c;

   // A store commits in the MEM cycle that sees ready, so its PC write cannot be registered
   assign st_commit_c = (state_q == S_MEM) && (cls_q == CLS_ST) && mem_ready_i;

   // Next state plus output decode of the state being entered
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      out_d   = '0;

      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            cls_d   = decode_op(op_i);
            state_d = (cls_d == CLS_ILL) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            state_d = ((cls_q == CLS_LD) || (cls_q == CLS_ST)) ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (mem_ready_i) begin
               if (cls_q == CLS_ST) state_d = start_i ? S_FETCH : S_IDLE;
               else                 state_d = S_WB;
            end
         end
         S_WB: begin
            state_d = start_i ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (state_d)
         S_FETCH: out_d.ir_we = 1'b1;
         S_MEM: begin
            out_d.mem_req = 1'b1;
            out_d.mem_we  = (cls_d == CLS_ST);
         end
         S_WB: begin
            out_d.reg_we = 1'b1;
            out_d.pc_we  = 1'b1;
         end
         S_HALT:  out_d.illegal = 1'b1;
         default: ;
      endcase

      if ((state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB)) begin
         case (cls_d)
            CLS_R: begin
               out_d.alu_src = 1'b0;
               out_d.alu_op  = ALUOP_R;
            end
            CLS_I: begin
               out_d.alu_src = 1'b1;
               out_d.alu_op  = ALUOP_I;
            end
            CLS_LD: begin
               out_d.alu_src = 1'b1;
               out_d.alu_op  = ALUOP_ADD;
               out_d.wb_sel  = 1'b1;
            end
            CLS_ST: begin
               out_d.alu_src = 1'b1;
               out_d.alu_op  = ALUOP_ADD;
            end
            default: ;
         endcase
      end

      out_d.busy = (state_d != S_IDLE) && (state_d != S_HALT);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cls_q   <= CLS_NONE;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         out_q   <= out_d;
      end
   end

   // Retire on every PC write; wraps naturally at the counter width
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         retired_q <= '0;
      end else if (pc_we_o) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign ir_we_o   = out_q.ir_we;
   assign pc_we_o   = out_q.pc_we | st_commit_c;
   assign reg_we_o  = out_q.reg_we;
   assign mem_req_o = out_q.mem_req;
   assign mem_we_o  = out_q.mem_we;
   assign alu_src_o = out_q.alu_src;
   assign alu_op_o  = out_q.alu_op;
   assign wb_sel_o  = out_q.wb_sel;
   assign busy_o    = out_q.busy;
   assign illegal_o = out_q.illegal;
   assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random traffic, checked every
// cycle against a per-instruction schedule model of the sequencer.
module tb_multicycle_ctrl;

   localparam int unsigned CW = 4;
   localparam logic [6:0] B_R  = 7'b0110011;
   localparam logic [6:0] B_I  = 7'b0010011;
   localparam logic [6:0] B_LD = 7'b0000011;
   localparam logic [6:0] B_ST = 7'b0100011;
   localparam logic [6:0] B_XX = 7'b1111111;

   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
   localparam int C_R = 1, C_I = 2, C_LD = 3, C_ST = 4, C_ILL = 5;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          start_i = 1'b0;
   logic [6:0]    op_i = '0;
   logic          mem_ready_i = 1'b0;
   logic          ir_we_o, pc_we_o, reg_we_o, mem_req_o, mem_we_o;
   logic          alu_src_o, wb_sel_o, busy_o, illegal_o;
   logic [1:0]    alu_op_o;
   logic [CW-1:0] retired_o;

   int total = 0;
   int bad   = 0;

   // Model: mode, cycle index inside current instruction, class, memory done flag
   int m_mode, m_step, m_cls, m_cnt;
   logic m_memdone;

   multicycle_ctrl #(.CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .mem_ready_i(mem_ready_i), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
      .reg_we_o(reg_we_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .alu_src_o(alu_src_o), .alu_op_o(alu_op_o), .wb_sel_o(wb_sel_o),
      .busy_o(busy_o), .illegal_o(illegal_o), .retired_o(retired_o)
   );

   always #5 clk_i = ~clk_i;

   wire [10:0] dut_vec = {ir_we_o, pc_we_o, reg_we_o, mem_req_o, mem_we_o,
                          alu_src_o, alu_op_o, wb_sel_o, busy_o, illegal_o};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int classify(input logic [6:0] op);
      if (op == B_R)  return C_R;
      if (op == B_I)  return C_I;
      if (op == B_LD) return C_LD;
      if (op == B_ST) return C_ST;
      return C_ILL;
   endfunction

   function automatic void m_reset();
      m_mode = M_IDLE; m_step = 0; m_cls = 0; m_cnt = 0; m_memdone = 1'b0;
   endfunction

   // Expected outputs for the current cycle; rdy matters only for a store commit
   function automatic logic [10:0] exp_vec(input logic rdy);
      logic ir, pc, rw, mr, mw, as, wb, bz, il;
      logic [1:0] ao;
      {ir, pc, rw, mr, mw, as, wb, bz, il} = '0;
      ao = 2'b00;
      if (m_mode == M_HALT) il = 1'b1;
      else if (m_mode == M_RUN) begin
         bz = 1'b1;
         if (m_step == 0) ir = 1'b1;
         if (m_step >= 2) begin
            if (m_cls == C_R) ao = 2'b10;
            if (m_cls == C_I) begin as = 1'b1; ao = 2'b11; end
            if (m_cls == C_LD) begin as = 1'b1; wb = 1'b1; end
            if (m_cls == C_ST) as = 1'b1;
         end
         if (m_step >= 3) begin
            if (m_cls == C_R || m_cls == C_I || m_memdone) begin
               rw = 1'b1; pc = 1'b1;
            end else begin
               mr = 1'b1;
               mw = (m_cls == C_ST);
               pc = (m_cls == C_ST) && rdy;
            end
         end
      end
      return {ir, pc, rw, mr, mw, as, ao, wb, bz, il};
   endfunction

   function automatic void m_tick(input logic s, input logic [6:0] op, input logic rdy);
      logic commit;
      commit = 1'b0;
      if (m_mode == M_IDLE) begin
         if (s) begin m_mode = M_RUN; m_step = 0; end
      end else if (m_mode == M_RUN) begin
         if (m_step == 0) m_step = 1;
         else if (m_step == 1) begin
            m_cls = classify(op);
            if (m_cls == C_ILL) m_mode = M_HALT;
            else m_step = 2;
         end else if (m_step == 2) begin
            m_step = 3; m_memdone = 1'b0;
         end else if (m_cls == C_R || m_cls == C_I || m_memdone) commit = 1'b1;
         else if (rdy) begin
            if (m_cls == C_ST) commit = 1'b1;
            else m_memdone = 1'b1;
         end
         if (commit) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            if (s) m_step = 0;
            else m_mode = M_IDLE;
         end
      end
   endfunction

   // One clock cycle: drive, compare against model, advance both
   task automatic cyc(input logic s, input logic [6:0] op, input logic rdy);
      start_i = s; op_i = op; mem_ready_i = rdy;
      #1;
      check("outs", 32'(dut_vec), 32'(exp_vec(rdy)));
      check("retired", 32'(retired_o), 32'(m_cnt));
      @(posedge clk_i);
      m_tick(s, op, rdy);
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_i = 1'b0; start_i = 1'b0; mem_ready_i = 1'b0;
      #1;
      m_reset();
      check("rst_outs", 32'(dut_vec), 32'd0);
      check("rst_retired", 32'(retired_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   initial begin
      logic s, rdy;
      logic [6:0] op;
      int r;
      m_reset();
      repeat (2) @(negedge clk_i);
      do_reset();

      // R-type with start held, then dropped at WB
      cyc(1, B_R, 0);
      check("r_ir_we", 32'(ir_we_o), 32'd1);
      cyc(1, B_R, 0);
      cyc(1, B_R, 0);
      check("r_alu_op", 32'(alu_op_o), 32'd2);
      check("r_alu_src", 32'(alu_src_o), 32'd0);
      cyc(1, B_R, 0);
      check("r_wb_en", 32'({reg_we_o, pc_we_o}), 32'd3);
      cyc(0, B_R, 0);
      check("r_retired", 32'(retired_o), 32'd1);

      // Load with three wait cycles before ready
      repeat (4) cyc(1, B_LD, 0);
      repeat (3) begin
         check("ld_memreq", 32'({mem_req_o, mem_we_o}), 32'd2);
         cyc(1, B_LD, 0);
      end
      cyc(0, B_LD, 1);
      check("ld_wb", 32'({wb_sel_o, reg_we_o}), 32'd3);
      cyc(0, B_LD, 0);
      check("ld_retired", 32'(retired_o), 32'd2);

      // Store with zero-wait ready, back-to-back into the next fetch
      repeat (4) cyc(1, B_ST, 0);
      start_i = 1'b1; mem_ready_i = 1'b1;
      #1;
      check("st_commit", 32'({pc_we_o, mem_we_o, reg_we_o}), 32'd6);
      cyc(1, B_ST, 1);
      check("st_next_fetch", 32'(ir_we_o), 32'd1);
      check("st_retired", 32'(retired_o), 32'd3);
      repeat (4) cyc(0, B_R, 0);
      check("r2_retired", 32'(retired_o), 32'd4);

      // Illegal opcode halts until reset
      repeat (3) cyc(1, B_XX, 0);
      check("halt_flags", 32'({illegal_o, busy_o}), 32'd2);
      repeat (20) cyc(1, B_XX, 1);
      check("halt_stays", 32'({illegal_o, pc_we_o, reg_we_o, mem_req_o}), 32'd8);
      do_reset();

      // start_i dropped during EXEC of an I-type
      repeat (3) cyc(1, B_I, 0);
      cyc(0, B_I, 0);
      cyc(0, B_I, 0);
      check("i_retired", 32'(retired_o), 32'd1);
      check("i_idle", 32'(dut_vec), 32'd0);
      cyc(0, B_I, 0);

      // Counter wrap: fifteen more R-types back to back
      cyc(1, B_R, 0);
      repeat (60) cyc(1, B_R, 0);
      check("wrap", 32'(retired_o), 32'd0);

      // Asynchronous reset in the middle of a MEM wait
      repeat (3) cyc(1, B_LD, 0);
      check("pre_rst_mem", 32'(mem_req_o), 32'd1);
      #2 rst_i = 1'b0;
      #1;
      check("async_rst", 32'(dut_vec), 32'd0);
      m_reset();
      @(negedge clk_i);
      rst_i = 1'b1;

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         if (m_mode == M_HALT && $urandom_range(0, 3) == 0) do_reset();
         s   = ($urandom_range(0, 9) != 0);
         rdy = ($urandom_range(0, 2) == 0);
         r   = int'($urandom_range(0, 19));
         if (r < 5)       op = B_R;
         else if (r < 10) op = B_I;
         else if (r < 15) op = B_LD;
         else if (r < 19) op = B_ST;
         else begin
            op = 7'($urandom);
            if (classify(op) != C_ILL) op = B_XX;
         end
         cyc(s, op, rdy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
